// File: rtl/tile_scheduler.sv
// Tile-level sequencer for a blocked (2*TILES)x(2*TILES) matrix multiply on a 2x2 systolic MMU.
// Walks i (outer), j, k (inner): loads A(i,k) and B(k,j), runs the MMU, accumulates, then writes back C(i,j).
module tile_scheduler #(
    parameter int TILES = 2,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             ld_valid,
    input  logic             ld_ready,
    output logic             ld_sel_ab,
    output logic [1:0]       ld_elem,
    output logic [IDX_W-1:0] ld_tile_row,
    output logic [IDX_W-1:0] ld_tile_col,
    output logic             mmu_start,
    output logic             acc_clear,
    input  logic             mmu_done,
    output logic             acc_en,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [1:0]       wb_elem,
    output logic [IDX_W-1:0] wb_tile_row,
    output logic [IDX_W-1:0] wb_tile_col,
    output logic [2:0]       dbg_state
);

    // Valid/ready: a transfer occurs in any cycle where valid and ready are both high;
    // valid and its payload are held unchanged while ready is low.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_START   = 3'd2,
        S_COMPUTE = 3'd3,
        S_ACC     = 3'd4,
        S_WB      = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(TILES - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] i_q, i_d;
    logic [IDX_W-1:0] j_q, j_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic [2:0]       elem_q, elem_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            elem_q  <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            elem_q  <= elem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        elem_d  = elem_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    elem_d  = '0;
                end
            end
            S_LOAD: begin
                if (ld_ready) begin
                    if (elem_q == 3'd7) begin
                        elem_d  = '0;
                        state_d = S_START;
                    end else begin
                        elem_d = elem_q + 3'd1;
                    end
                end
            end
            S_START: state_d = S_COMPUTE;
            S_COMPUTE: begin
                if (mmu_done) state_d = S_ACC;
            end
            S_ACC: begin
                if (k_q < LAST) begin
                    k_d     = k_q + 1'b1;
                    state_d = S_LOAD;
                end else begin
                    elem_d  = '0;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                if (wb_ready) begin
                    if (elem_q[1:0] == 2'd3) begin
                        elem_d = '0;
                        k_d    = '0;
                        if (j_q < LAST) begin
                            j_d     = j_q + 1'b1;
                            state_d = S_LOAD;
                        end else if (i_q < LAST) begin
                            i_d     = i_q + 1'b1;
                            j_d     = '0;
                            state_d = S_LOAD;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        elem_d = elem_q + 3'd1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort wins over everything; a handshake in this cycle is dropped from the count.
        if (abort) begin
            state_d = S_IDLE;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            elem_d  = '0;
        end
    end

    // Outputs depend only on registered state and counters; payloads read 0 when not valid.
    always_comb begin
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        ld_valid    = 1'b0;
        ld_sel_ab   = 1'b0;
        ld_elem     = '0;
        ld_tile_row = '0;
        ld_tile_col = '0;
        mmu_start   = 1'b0;
        acc_clear   = 1'b0;
        acc_en      = 1'b0;
        wb_valid    = 1'b0;
        wb_elem     = '0;
        wb_tile_row = '0;
        wb_tile_col = '0;
        dbg_state   = state_q;
        case (state_q)
            S_LOAD: begin
                ld_valid    = 1'b1;
                ld_sel_ab   = elem_q[2];
                ld_elem     = elem_q[1:0];
                ld_tile_row = elem_q[2] ? k_q : i_q;
                ld_tile_col = elem_q[2] ? j_q : k_q;
            end
            S_START: begin
                mmu_start = 1'b1;
                acc_clear = (k_q == '0);
            end
            S_ACC: acc_en = 1'b1;
            S_WB: begin
                wb_valid    = 1'b1;
                wb_elem     = elem_q[1:0];
                wb_tile_row = i_q;
                wb_tile_col = j_q;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/tile_scheduler.md
Name: tile_scheduler

Overview:
Sequences a blocked matrix multiply C = A x B of size (2*TILES)x(2*TILES) through the 2x2 systolic MMU, one 2x2 tile at a time.
- For each output tile (i,j) and each k it loads A tile (i,k) and B tile (k,j) element-by-element into matrix memory, starts the MMU and accumulates the partial product.
- After the last k it writes the C tile out over a valid/ready port.
- Sits between the host command path and the matrix memory / MMU / accumulator.

Parameters:
TILES, 2, tiles per matrix dimension (legal 1..4)
IDX_W, 2, width of tile coordinate outputs (must hold TILES-1)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  begin a full multiply; sampled only in IDLE
abort  in  1  cancel current operation
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on completion
ld_valid  out  1  element load request to matrix memory
ld_ready  in  1  memory accepts element this cycle
ld_sel_ab  out  1  0 = A (weights), 1 = B (inputs)
ld_elem  out  2  element index in tile, row-major
ld_tile_row  out  IDX_W  source tile row
ld_tile_col  out  IDX_W  source tile column
mmu_start  out  1  one-cycle MMU kick
acc_clear  out  1  with mmu_start: accumulator overwrites instead of adds
mmu_done  in  1  MMU result ready (pulse)
acc_en  out  1  one-cycle accumulate strobe
wb_valid  out  1  C element available
wb_ready  in  1  sink accepts C element
wb_elem  out  2  C element index, row-major
wb_tile_row  out  IDX_W  output tile row (i)
wb_tile_col  out  IDX_W  output tile column (j)

Behaviour:
- Reset (async, rst high):
  - state = IDLE; counters i, j, k and elem cleared.
  - All outputs 0.
- States and outputs:
  - States: IDLE, LOAD, START, COMPUTE, ACC, WB, DONE.
  - All outputs are decoded from registered state and counters; no combinational path from any input to any output.
- IDLE:
  - start=1 -> LOAD with i=j=k=0, elem=0.
  - start is ignored in all other states.
- LOAD:
  - ld_valid=1.
  - Transfer order: A e0..e3, then B e0..e3; ld_sel_ab = elem[2], ld_elem = elem[1:0].
  - A transfers use tile (row=i, col=k); B transfers use tile (row=k, col=j).
  - elem advances only on ld_valid & ld_ready. Outputs hold stable while ld_ready=0.
  - 8th handshake -> START, elem=0.
- START (1 cycle):
  - mmu_start=1; acc_clear = (k==0).
  - -> COMPUTE.
- COMPUTE:
  - Waits for mmu_done. mmu_done is ignored in every other state, including the START cycle.
  - mmu_done=1 -> ACC.
- ACC (1 cycle):
  - acc_en=1.
  - If k<TILES-1: k++ and -> LOAD; otherwise -> WB, elem=0.
- WB:
  - wb_valid=1, wb_elem = elem[1:0], wb_tile_row=i, wb_tile_col=j.
  - elem advances only on wb_valid & wb_ready; outputs stable while stalled.
  - 4th handshake:
    - If j<TILES-1: j++, k=0, -> LOAD.
    - Else if i<TILES-1: i++, j=0, k=0, -> LOAD.
    - Else -> DONE.
- DONE (1 cycle):
  - done=1, busy=1.
  - -> IDLE.
- Loop order: i outermost, j, k innermost. Exactly TILES^2 output tiles and TILES^3 MMU ops per start.
- Timing: with ld_ready=wb_ready=1 and MMU latency L (cycles from mmu_start to mmu_done):
  - Each k-iteration takes 8+1+L+1 cycles.
  - Each output tile adds 4 WB cycles.
- abort:
  - abort=1 in any state -> IDLE at the next edge; counters cleared, no done pulse.
  - abort has priority over every other transition, including start in IDLE.
  - A handshake completing in the abort cycle is still consumed by the peer but is not counted.
- Simultaneous events:
  - ld_ready/wb_ready asserted outside LOAD/WB are ignored.
  - mmu_done arriving in ACC or LOAD is ignored (no double accumulate).
- TILES=1: a single k-iteration per tile; acc_clear is always 1 with mmu_start; done follows 4 WB handshakes.

Test Plan:
1. Reset mid-LOAD (after 3 handshakes) -> all outputs 0 the same cycle rst rises; after release, busy=0 until the next start.
2. TILES=2, ld_ready=wb_ready=1, mmu_done 3 cycles after mmu_start:
   - Exactly 8 mmu_start pulses; acc_clear on pulses 1,3,5,7; 8 acc_en pulses; 16 wb handshakes.
   - Load coordinate sequence for tile (0,1): A(0,0), B(0,1), A(0,1), B(1,1).
   - done at cycle 4*(2*(8+1+3+1)+4)+1 = 121 after start (start in cycle 0, done in cycle 121).
3. Backpressure: ld_ready toggled 1010..., wb_ready low for 5 cycles mid-WB -> ld/wb address outputs stable while not ready; no element skipped or repeated; totals unchanged.
4. Spurious/overlapping inputs:
   - start asserted during COMPUTE and WB -> ignored.
   - mmu_done pulsed in LOAD and in ACC -> ignored; acc_en count stays TILES^3.
5. abort during WB of tile (1,0) with TILES=2 -> IDLE next cycle, no done; a following start replays from tile (0,0) with acc_clear on the first mmu_start.
6. TILES=1 -> 8 loads, 1 mmu_start with acc_clear=1, 1 acc_en, 4 wb handshakes, done pulse, all coordinates 0.
